// File: rtl/motor_countdown_pwm_pkg.sv
// Shared types and constants for the motor countdown controller:
// FSM state encoding, BCD time representation and the BCD step helpers.
package motor_countdown_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int BCD_MAX = 99;
  localparam int STEP    = 10;

  localparam logic [3:0] MAX_TENS  = 4'(BCD_MAX / 10);
  localparam logic [3:0] MAX_ONES  = 4'(BCD_MAX % 10);
  localparam logic [3:0] STEP_TENS = 4'(STEP / 10);

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // time + STEP, clamped at BCD_MAX
  function automatic bcd_t bcd_add_step(input bcd_t t);
    bcd_t r;
    if (t.tens >= MAX_TENS - STEP_TENS + 4'd1) begin
      r.tens = MAX_TENS;
      r.ones = MAX_ONES;
    end else begin
      r.tens = t.tens + STEP_TENS;
      r.ones = t.ones;
    end
    return r;
  endfunction

  // time - 1 with a borrow from the tens digit; caller guarantees time != 00
  function automatic bcd_t bcd_dec(input bcd_t t);
    bcd_t r;
    if (t.ones == 4'd0) begin
      r.tens = t.tens - 4'd1;
      r.ones = 4'd9;
    end else begin
      r.tens = t.tens;
      r.ones = t.ones - 4'd1;
    end
    return r;
  endfunction

  // time - 1 + STEP, clamped at BCD_MAX; time is never 00 while counting
  function automatic bcd_t bcd_dec_add_step(input bcd_t t);
    return bcd_add_step(bcd_dec(t));
  endfunction

endpackage

// File: rtl/motor_countdown_pwm_pwm_gen.sv
// Free-running PWM generator: one period counter and four duty comparators
// giving 25/50/75/100 % duty on o_motor[0..3].
module pwm_gen #(
  parameter int PWM_PERIOD = 100
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic [3:0] o_motor
);

  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  logic [CW-1:0] pwm_cnt;

  // period counter, wraps at PWM_PERIOD-1 in every controller state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      pwm_cnt <= '0;
    else if (pwm_cnt == CW'(PWM_PERIOD - 1))
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + 1'b1;
  end

  // registered duty comparators; thresholds compared at 32 bits because
  // the top threshold equals PWM_PERIOD and does not fit the counter width
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      o_motor <= 4'b0000;
    else
      for (int k = 0; k < 4; k++)
        o_motor[k] <= (32'(pwm_cnt) < 32'((k + 1) * PWM_PERIOD / 4));
  end

endmodule

// File: rtl/motor_countdown_pwm.sv
// Motor countdown controller: start/stop/add pulse FSM, one-second divider,
// two-digit BCD time counter and a PWM generator for the motor drive levels.
//
// state | meaning
// IDLE  | stopped, second divider cleared, time editable with add
// RUN   | second divider counting, time decrements on each tick
// PAUSE | divider and time held; start resumes, stop clears to IDLE
module motor_countdown_pwm
  import motor_countdown_pwm_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PWM_PERIOD = 100
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_add,
  output logic [3:0] o_motor,
  output logic [3:0] o_sec_10,
  output logic [3:0] o_sec_1,
  output logic       o_running,
  output logic       o_done
);

  localparam int SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  state_t        state;
  bcd_t          tm;
  logic [SW-1:0] sec_cnt;
  logic          tick;

  // a stop pulse freezes the divider in that cycle, so a coincident wrap is
  // deferred until the countdown resumes
  assign tick = (state == RUN) && !i_stop && (sec_cnt == SW'(CLK_HZ - 1));

  assign o_sec_10 = tm.tens;
  assign o_sec_1  = tm.ones;

  pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_motor (o_motor)
  );

  // one-second divider: counts in RUN, holds in PAUSE, cleared in IDLE
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      sec_cnt <= '0;
    else begin
      case (state)
        RUN: begin
          if (tick)
            sec_cnt <= '0;
          else if (!i_stop)
            sec_cnt <= sec_cnt + 1'b1;
        end
        PAUSE:   sec_cnt <= sec_cnt;
        default: sec_cnt <= '0;
      endcase
    end
  end

  // control FSM with the BCD time register and registered status outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      tm        <= '0;
      o_running <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && (tm != '0)) begin
            state     <= RUN;
            o_running <= 1'b1;
          end else if (i_add) begin
            tm <= bcd_add_step(tm);
          end
        end
        RUN: begin
          if (i_stop) begin
            state     <= PAUSE;
            o_running <= 1'b0;
          end else if (tick) begin
            if (i_add)
              tm <= bcd_dec_add_step(tm);
            else begin
              tm <= bcd_dec(tm);
              if ({tm.tens, tm.ones} == 8'h01) begin
                state     <= IDLE;
                o_running <= 1'b0;
                o_done    <= 1'b1;
              end
            end
          end else if (i_add) begin
            tm <= bcd_add_step(tm);
          end
        end
        PAUSE: begin
          if (i_stop) begin
            state <= IDLE;
            tm    <= '0;
          end else if (i_start) begin
            state     <= RUN;
            o_running <= 1'b1;
          end else if (i_add) begin
            tm <= bcd_add_step(tm);
          end
        end
        default: begin
          state     <= IDLE;
          o_running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_countdown_pwm.sv
// Self-checking bench for motor_countdown_pwm (CLK_HZ=10, PWM_PERIOD=8):
// directed scenarios followed by random pulses, all checked against an
// arithmetic model of remaining seconds, pause/run flags and PWM phase.
module tb_motor_countdown_pwm;

  localparam int CLK_HZ = 10;
  localparam int PWM    = 8;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_add = 1'b0;
  logic [3:0] o_motor;
  logic [3:0] o_sec_10;
  logic [3:0] o_sec_1;
  logic       o_running;
  logic       o_done;

  motor_countdown_pwm #(
    .CLK_HZ     (CLK_HZ),
    .PWM_PERIOD (PWM)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_add     (i_add),
    .o_motor   (o_motor),
    .o_sec_10  (o_sec_10),
    .o_sec_1   (o_sec_1),
    .o_running (o_running),
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: remaining seconds as a plain integer
  int       m_time;
  bit       m_run;
  bit       m_hold;
  int       m_phase;
  int       m_pwm;
  bit       m_done;
  bit [3:0] m_motor;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int min99(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic model_reset();
    m_time = 0; m_run = 0; m_hold = 0; m_phase = 0;
    m_pwm = 0; m_done = 0; m_motor = 4'b0000;
  endtask

  task automatic model_step(input bit s, input bit p, input bit a);
    bit tk;
    for (int k = 0; k < 4; k++) m_motor[k] = (m_pwm < (k + 1) * PWM / 4);
    m_pwm  = (m_pwm + 1) % PWM;
    m_done = 0;
    if (m_run) begin
      if (p) begin
        m_run = 0; m_hold = 1;
      end else begin
        tk = (m_phase == CLK_HZ - 1);
        m_phase = tk ? 0 : m_phase + 1;
        if (tk) begin
          m_time = min99(m_time - 1 + (a ? 10 : 0));
          if (m_time == 0) begin
            m_run = 0; m_done = 1;
          end
        end else if (a) m_time = min99(m_time + 10);
      end
    end else if (m_hold) begin
      if (p) begin
        m_time = 0; m_hold = 0; m_phase = 0;
      end else if (s) begin
        m_hold = 0; m_run = 1;
      end else if (a) m_time = min99(m_time + 10);
    end else begin
      m_phase = 0;
      if (s && m_time != 0) m_run = 1;
      else if (a) m_time = min99(m_time + 10);
    end
  endtask

  task automatic compare_all();
    check_val("sec_10", int'(o_sec_10), m_time / 10);
    check_val("sec_1", int'(o_sec_1), m_time % 10);
    check_val("running", int'(o_running), int'(m_run));
    check_val("done", int'(o_done), int'(m_done));
    check_val("motor", int'(o_motor), int'(m_motor));
  endtask

  // called at posedge+1; leaves time at the following posedge+1
  task automatic cycle(input bit s, input bit p, input bit a);
    i_start = s; i_stop = p; i_add = a;
    @(posedge i_clk);
    model_step(s, p, a);
    #1;
    i_start = 0; i_stop = 0; i_add = 0;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  // asynchronous reset asserted between edges, checked before any edge
  task automatic do_reset();
    #2;
    i_reset = 1;
    #1;
    model_reset();
    compare_all();
    @(posedge i_clk);
    #1;
    compare_all();
    i_reset = 0;
  endtask

  task automatic run_until_time(input int t, input string tag);
    int guard = 0;
    while (m_time != t && guard < 400) begin
      cycle(0, 0, 0);
      guard++;
    end
    check_val(tag, m_time, t);
  endtask

  initial begin
    int cnt [4];
    int dones;
    int guard;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    compare_all();
    i_reset = 0;

    // PWM duty over one full period
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int i = 0; i < PWM; i++) begin
      cycle(0, 0, 0);
      for (int k = 0; k < 4; k++) cnt[k] += int'(o_motor[k]);
    end
    for (int k = 0; k < 4; k++) check_val("duty", cnt[k], 2 * (k + 1));

    // 10 s countdown to done
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    dones = 0;
    for (int i = 0; i < 110; i++) begin
      cycle(0, 0, 0);
      dones += int'(o_done);
    end
    check_val("done_count", dones, 1);
    check_val("end_sec", int'({o_sec_10, o_sec_1}), 0);

    // pause holds, resume, double stop clears
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    idle_cycles(25);
    check_val("at_18", int'({o_sec_10, o_sec_1}), 8'h18);
    cycle(0, 1, 0);
    idle_cycles(50);
    check_val("held_18", int'({o_sec_10, o_sec_1}), 8'h18);
    cycle(1, 0, 0);
    idle_cycles(20);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    check_val("cleared", int'({o_sec_10, o_sec_1, 3'b000, o_running}), 0);

    // saturation and stop-over-start priority in PAUSE
    for (int i = 0; i < 12; i++) cycle(0, 0, 1);
    check_val("sat_99", int'({o_sec_10, o_sec_1}), 8'h99);
    cycle(1, 0, 0);
    idle_cycles(3);
    cycle(0, 1, 0);
    cycle(1, 1, 0);
    check_val("prio_clear", int'({o_sec_10, o_sec_1, 3'b000, o_running}), 0);

    // add coincident with a tick at 05
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    run_until_time(5, "reach_05");
    guard = 0;
    while (m_phase != CLK_HZ - 1 && guard < 20) begin
      cycle(0, 0, 0);
      guard++;
    end
    cycle(0, 0, 1);
    check_val("tick_add_14", int'({o_sec_10, o_sec_1}), 8'h14);
    cycle(0, 1, 0);
    cycle(0, 1, 0);

    // start at 00 is ignored
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check_val("start_at_00", int'(o_running), 0);

    // asynchronous reset mid-run at 37
    for (int i = 0; i < 4; i++) cycle(0, 0, 1);
    cycle(1, 0, 0);
    run_until_time(37, "reach_37");
    idle_cycles(4);
    do_reset();
    idle_cycles(12);

    // random pulses with occasional reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
